// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the single-port work/video RAM between the CPU and the
// hiscore save/restore engine. The CPU is paused and must report a halt before
// the port is handed to the hiscore side, and it gets the port back after a
// short settle period.
// Optional feature: define HS_ARB_TIMEOUT_EN to bound the halt wait by TIMEOUT
// cycles and flag a sticky hs_err when the CPU never halts.
module hs_ram_arbiter #(
   parameter int unsigned AW      = 14,
   parameter int unsigned DW      = 8,
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ce_5M,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   input  logic          cpu_we,
   input  logic          cpu_halted,
   output logic          cpu_pause,
   input  logic          hs_req,
   input  logic          hs_stb,
   input  logic          hs_we,
   input  logic [AW-1:0] hs_addr,
   input  logic [DW-1:0] hs_din,
   output logic          hs_ack,
   output logic [DW-1:0] hs_dout,
   output logic          hs_grant,
   output logic          hs_err,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   localparam int unsigned SW = 4;

   // Catch out-of-range configuration at elaboration time
   if (SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1) begin : g_param_check
      $error("hs_ram_arbiter: SETTLE must be 1..15 and TIMEOUT at least 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAUSING,
      ST_GRANTED,
      ST_READ_WAIT,
      ST_RELEASE
   } state_e;

   state_e          state_q, state_d;
   logic            pause_q, pause_d;
   logic            grant_q, grant_d;
   logic            ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   din_q, din_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic            accept_c;
   logic            hs_side_c;

`ifdef HS_ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0]   to_q, to_d;
   logic            err_q, err_d;
`endif

   // A strobe is taken only while granted, idle and the session is still open
   assign accept_c = (state_q == ST_GRANTED) && !busy_q && hs_req && hs_stb;

   // Next-state and register update logic
   always_comb begin
      state_d  = state_q;
      pause_d  = pause_q;
      grant_d  = grant_q;
      ack_d    = 1'b0;
      busy_d   = accept_c;
      we_d     = we_q;
      addr_d   = addr_q;
      din_d    = din_q;
      dout_d   = dout_q;
      settle_d = settle_q;
`ifdef HS_ARB_TIMEOUT_EN
      to_d     = to_q;
      err_d    = err_q;
`endif

      if (accept_c) begin
         we_d   = hs_we;
         addr_d = hs_addr;
         din_d  = hs_din;
      end

      case (state_q)
         ST_IDLE: begin
            pause_d = 1'b0;
            grant_d = 1'b0;
            if (hs_req) begin
               state_d = ST_PAUSING;
               pause_d = 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
               to_d    = '0;
`endif
            end
         end

         ST_PAUSING: begin
            if (!hs_req) begin
               state_d  = ST_RELEASE;
               grant_d  = 1'b0;
               settle_d = '0;
            end else if (ce_5M && cpu_halted) begin
               state_d = ST_GRANTED;
               grant_d = 1'b1;
            end
`ifdef HS_ARB_TIMEOUT_EN
            else if (to_q == TW'(TIMEOUT - 1)) begin
               err_d    = 1'b1;
               state_d  = ST_RELEASE;
               grant_d  = 1'b0;
               settle_d = '0;
            end else begin
               to_d = to_q + TW'(1);
            end
`endif
         end

         ST_GRANTED: begin
            if (busy_q) begin
               // RAM cycle happens this cycle; reads wait one more for the data
               ack_d = 1'b1;
               if (!we_q) begin
                  state_d = ST_READ_WAIT;
               end
            end else if (!hs_req) begin
               state_d  = ST_RELEASE;
               grant_d  = 1'b0;
               settle_d = '0;
            end
         end

         ST_READ_WAIT: begin
            dout_d = ram_dout;
            if (hs_req) begin
               state_d = ST_GRANTED;
            end else begin
               state_d  = ST_RELEASE;
               grant_d  = 1'b0;
               settle_d = '0;
            end
         end

         ST_RELEASE: begin
            // Keep the CPU paused for SETTLE cycles after the port returns
            if (settle_q == SW'(SETTLE - 1)) begin
               state_d = ST_IDLE;
               pause_d = 1'b0;
            end else if (settle_q != {SW{1'b1}}) begin
               settle_d = settle_q + SW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            pause_d = 1'b0;
            grant_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         pause_q  <= 1'b0;
         grant_q  <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         dout_q   <= '0;
         settle_q <= '0;
`ifdef HS_ARB_TIMEOUT_EN
         to_q     <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pause_q  <= pause_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         dout_q   <= dout_d;
         settle_q <= settle_d;
`ifdef HS_ARB_TIMEOUT_EN
         to_q     <= to_d;
         err_q    <= err_d;
`endif
      end
   end

   // RAM port mux, steered purely by the current state
   assign hs_side_c = (state_q == ST_GRANTED) || (state_q == ST_READ_WAIT);
   assign ram_addr  = hs_side_c ? addr_q : cpu_addr;
   assign ram_din   = hs_side_c ? din_q  : cpu_din;
   assign ram_we    = hs_side_c ? (busy_q & we_q) : (cpu_we & ce_5M);

   // Read data shows the RAM output in the ack cycle, then holds the captured byte
   assign hs_dout   = (state_q == ST_READ_WAIT) ? ram_dout : dout_q;
   assign cpu_pause = pause_q;
   assign hs_grant  = grant_q;
   assign hs_ack    = ack_q;
`ifdef HS_ARB_TIMEOUT_EN
   assign hs_err    = err_q;
`else
   assign hs_err    = 1'b0;
`endif

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game's single-port work/video RAM (16 KB, 14-bit address) between the CPU and the hiscore save/restore engine.
- On a hiscore session request it pauses the CPU and waits for the CPU to confirm it has halted. It then switches the RAM port to the hiscore side and executes single-byte read and write strobes. When the session ends it hands the port back to the CPU.
- Sits in the game top between the CPU/RAM path and the hiscore module, replacing the ad-hoc pause/access OR-ing.

Parameters:
- AW, 14, RAM address width.
- DW, 8, RAM data width.
- SETTLE, 2, number of clk_sys cycles cpu_pause is held after the port is returned to the CPU (range 1..15).
- TIMEOUT, 1024, halt-wait limit in clk_sys cycles; used only with HS_ARB_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock (10 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ce_5M  in  1  CPU clock enable.
- cpu_addr  in  AW  CPU RAM address.
- cpu_din  in  DW  CPU write data.
- cpu_we  in  1  CPU write enable, qualified by ce_5M.
- cpu_halted  in  1  CPU has stopped at an instruction boundary.
- cpu_pause  out  1  pause request to the CPU.
- hs_req  in  1  level; a hiscore session is active while high.
- hs_stb  in  1  one-cycle access strobe.
- hs_we  in  1  1 = write, 0 = read; sampled with hs_stb.
- hs_addr  in  AW  hiscore address; sampled with hs_stb.
- hs_din  in  DW  hiscore write data; sampled with hs_stb.
- hs_ack  out  1  one-cycle pulse marking access completion.
- hs_dout  out  DW  read data, valid while hs_ack is high.
- hs_grant  out  1  RAM port currently owned by the hiscore side.
- hs_err  out  1  sticky halt-timeout flag (macro only; otherwise tied 0).
- ram_addr  out  AW  RAM port address.
- ram_din  out  DW  RAM port write data.
- ram_we  out  1  RAM port write enable.
- ram_dout  in  DW  RAM read data, registered, 1-cycle latency.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - state=IDLE; all internal registers cleared.
  - cpu_pause=0, hs_grant=0, hs_ack=0, hs_dout=0, hs_err=0.
  - RAM mux selects the CPU side.
  - A reset asserted mid-session aborts the session with no ack.
- RAM mux is combinational from state:
  - CPU side: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we&ce_5M.
  - HS side: ram_addr, ram_din and ram_we come from registered hs_* values.
- States:
  - IDLE: cpu_pause=0. hs_req=1 → PAUSING, with cpu_pause=1 from the next cycle.
  - PAUSING: cpu_pause=1; waits for cpu_halted=1 sampled on a ce_5M=1 cycle → GRANTED, with hs_grant=1 next cycle. hs_req=0 → RELEASE.
  - GRANTED: each hs_stb latches hs_addr, hs_din and hs_we.
    - Write: ram_we=1 for exactly one cycle (cycle N+1); hs_ack pulses at cycle N+2.
    - Read: ram_addr driven at N+1, READ_WAIT at N+2, hs_ack and hs_dout=ram_dout at N+2.
    - Read-to-ack latency is 2 cycles; write-to-ack latency is 2 cycles.
    - hs_req=0 with no access in flight → RELEASE.
  - READ_WAIT: captures ram_dout, pulses hs_ack, → GRANTED.
  - RELEASE: hs_grant=0 and mux returns to the CPU immediately. cpu_pause stays 1 for SETTLE cycles, then → IDLE with cpu_pause=0.
- Boundary conditions:
  - hs_stb outside GRANTED, or while an access is in flight, is ignored: no ack, no RAM cycle.
  - hs_req dropping while an access is in flight: the access completes and acks, then → RELEASE.
  - hs_req re-asserted during RELEASE: RELEASE completes, then IDLE → PAUSING on the next cycle. No back-to-back grant without a settle period.
  - cpu_halted falling while GRANTED: no effect; the grant holds until hs_req drops.
  - The SETTLE counter is 4 bits and saturates; it never wraps.

Optional Feature:
- Macro: HS_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in PAUSING.
  - Reaching TIMEOUT cycles without a halt sets hs_err (sticky until reset) and → RELEASE; no grant is given.
  - The counter clears on entry to PAUSING.
- Undefined:
  - PAUSING waits indefinitely.
  - hs_err is tied 0 and no counter logic exists.

Test Plan:
- Reset release, then hs_req=1 with cpu_halted=1 on the 3rd ce_5M cycle → cpu_pause=1 one cycle after hs_req; hs_grant=1 one cycle after the qualified halt.
- Granted; hs_stb write addr=0x1A40, data=0x5C → ram_we high for exactly 1 cycle with ram_addr=0x1A40 and ram_din=0x5C; hs_ack 2 cycles after the strobe. A subsequent read of 0x1A40 → hs_dout=0x5C with hs_ack 2 cycles after the strobe.
- hs_stb asserted while in PAUSING, and a second strobe during READ_WAIT → no ram_we, no extra hs_ack; ram_addr tracks cpu_addr while in PAUSING.
- hs_req drops during a pending read → that read acks; hs_grant falls; cpu_pause stays high exactly SETTLE=2 cycles, then 0. CPU write cpu_addr=0x0100 with ce_5M and cpu_we → ram_we asserted.
- reset_n pulled low mid-GRANTED → all outputs immediately at reset values and mux on CPU; the next hs_req restarts from PAUSING.
- HS_ARB_TIMEOUT_EN with TIMEOUT=16 and cpu_halted held 0 → hs_err=1 at cycle 16 of PAUSING; no grant; cpu_pause returns to 0 after SETTLE cycles.
